// File: rtl/cdb_broadcaster.sv
// Per-unit result buffers feeding a round-robin common data bus: one (tag, value) per cycle,
// 1-cycle accept-to-broadcast latency; a unit sees ready low only while its buffer is full.
module cdb_broadcaster #(
  parameter int DATA_W = 8,
  parameter int TAG_W  = 4,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              add_valid,
  input  logic [TAG_W-1:0]  add_tag,
  input  logic [DATA_W-1:0] add_data,
  output logic              add_ready,
  input  logic              mult_valid,
  input  logic [TAG_W-1:0]  mult_tag,
  input  logic [DATA_W-1:0] mult_data,
  output logic              mult_ready,
  input  logic              fetch_valid,
  input  logic [TAG_W-1:0]  fetch_tag,
  input  logic [DATA_W-1:0] fetch_data,
  output logic              fetch_ready,
  output logic              cdb_valid,
  output logic [TAG_W-1:0]  cdb_tag,
  output logic [DATA_W-1:0] cdb_data,
  output logic [1:0]        adder_done,
  output logic [1:0]        mult_done,
  output logic [1:0]        fetch_done,
  output logic              bad_tag
);

  localparam int NU    = 3;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } beat_t;

  logic [NU-1:0] in_vld;
  beat_t         in_beat [NU];
  logic [NU-1:0] full;
  logic [NU-1:0] push;
  logic [NU-1:0] pop;
  logic [NU-1:0] bad_beat;

  beat_t            mem_q    [NU][DEPTH];
  beat_t            mem_d    [NU][DEPTH];
  logic [PTR_W-1:0] wr_ptr_q [NU];
  logic [PTR_W-1:0] wr_ptr_d [NU];
  logic [PTR_W-1:0] rd_ptr_q [NU];
  logic [PTR_W-1:0] rd_ptr_d [NU];
  logic [CNT_W-1:0] cnt_q    [NU];
  logic [CNT_W-1:0] cnt_d    [NU];

  logic [1:0]        rr_q, rr_d;
  logic              grant_vld;
  logic [1:0]        grant_idx;
  beat_t             head;

  logic              cdb_valid_q, cdb_valid_d;
  logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
  logic [DATA_W-1:0] cdb_data_q, cdb_data_d;
  logic [5:0]        done_q, done_d;
  logic              bad_tag_q, bad_tag_d;

  // Unit u owns the RS tag pair {2u+1, 2u+2}.
  function automatic logic tag_legal(input int unit, input logic [TAG_W-1:0] tag);
    return (tag == TAG_W'(2 * unit + 1)) || (tag == TAG_W'(2 * unit + 2));
  endfunction

  assign in_vld[0]  = add_valid;
  assign in_vld[1]  = mult_valid;
  assign in_vld[2]  = fetch_valid;
  assign in_beat[0] = {add_tag, add_data};
  assign in_beat[1] = {mult_tag, mult_data};
  assign in_beat[2] = {fetch_tag, fetch_data};

  always_comb begin
    for (int u = 0; u < NU; u++) begin
      full[u] = (cnt_q[u] == CNT_W'(DEPTH));
    end
  end

  always_comb begin : arb
    int cand;
    cand      = 0;
    grant_vld = 1'b0;
    grant_idx = 2'd0;
    head      = '0;
    pop       = '0;
    for (int k = 0; k < NU; k++) begin
      cand = (int'(rr_q) + k) % NU;
      if (!grant_vld && (cnt_q[cand] != '0)) begin
        grant_vld = 1'b1;
        grant_idx = 2'(cand);
        head      = mem_q[cand][rd_ptr_q[cand]];
        pop[cand] = 1'b1;
      end
    end
    rr_d = rr_q;
    if (grant_vld) begin
      rr_d = (grant_idx == 2'd2) ? 2'd0 : grant_idx + 2'd1;
    end
  end

  // Illegal beats are still handshaken so the producer never stalls on them.
  always_comb begin
    for (int u = 0; u < NU; u++) begin
      mem_d[u]    = mem_q[u];
      wr_ptr_d[u] = wr_ptr_q[u];
      rd_ptr_d[u] = rd_ptr_q[u];
      cnt_d[u]    = cnt_q[u];
      push[u]     = in_vld[u] && !full[u] && tag_legal(u, in_beat[u].tag);
      bad_beat[u] = in_vld[u] && !full[u] && !tag_legal(u, in_beat[u].tag);
      if (push[u]) begin
        mem_d[u][wr_ptr_q[u]] = in_beat[u];
        wr_ptr_d[u]           = wr_ptr_q[u] + PTR_W'(1);
      end
      if (pop[u]) begin
        rd_ptr_d[u] = rd_ptr_q[u] + PTR_W'(1);
      end
      case ({push[u], pop[u]})
        2'b10:   cnt_d[u] = cnt_q[u] + CNT_W'(1);
        2'b01:   cnt_d[u] = cnt_q[u] - CNT_W'(1);
        default: cnt_d[u] = cnt_q[u];
      endcase
    end
  end

  always_comb begin
    cdb_valid_d = grant_vld;
    cdb_tag_d   = grant_vld ? head.tag : '0;
    cdb_data_d  = grant_vld ? head.data : '0;
    for (int j = 0; j < 6; j++) begin
      done_d[j] = grant_vld && (head.tag == TAG_W'(j + 1));
    end
    bad_tag_d = |bad_beat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int u = 0; u < NU; u++) begin
        for (int i = 0; i < DEPTH; i++) begin
          mem_q[u][i] <= '0;
        end
        wr_ptr_q[u] <= '0;
        rd_ptr_q[u] <= '0;
        cnt_q[u]    <= '0;
      end
      rr_q        <= 2'd0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_data_q  <= '0;
      done_q      <= '0;
      bad_tag_q   <= 1'b0;
    end else begin
      for (int u = 0; u < NU; u++) begin
        mem_q[u]    <= mem_d[u];
        wr_ptr_q[u] <= wr_ptr_d[u];
        rd_ptr_q[u] <= rd_ptr_d[u];
        cnt_q[u]    <= cnt_d[u];
      end
      rr_q        <= rr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_data_q  <= cdb_data_d;
      done_q      <= done_d;
      bad_tag_q   <= bad_tag_d;
    end
  end

  assign add_ready   = !full[0];
  assign mult_ready  = !full[1];
  assign fetch_ready = !full[2];
  assign cdb_valid   = cdb_valid_q;
  assign cdb_tag     = cdb_tag_q;
  assign cdb_data    = cdb_data_q;
  assign adder_done  = done_q[1:0];
  assign mult_done   = done_q[3:2];
  assign fetch_done  = done_q[5:4];
  assign bad_tag     = bad_tag_q;

endmodule

// File: tb/tb_cdb_broadcaster.sv
// Directed and random stimulus for cdb_broadcaster, checked every cycle against a queue-based model.
module tb_cdb_broadcaster;
  localparam int DATA_W = 8;
  localparam int TAG_W  = 4;
  localparam int DEPTH  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              add_valid, mult_valid, fetch_valid;
  logic [TAG_W-1:0]  add_tag, mult_tag, fetch_tag;
  logic [DATA_W-1:0] add_data, mult_data, fetch_data;
  logic              add_ready, mult_ready, fetch_ready;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic [1:0]        adder_done, mult_done, fetch_done;
  logic              bad_tag;

  cdb_broadcaster #(.DATA_W(DATA_W), .TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .add_valid(add_valid), .add_tag(add_tag), .add_data(add_data), .add_ready(add_ready),
    .mult_valid(mult_valid), .mult_tag(mult_tag), .mult_data(mult_data), .mult_ready(mult_ready),
    .fetch_valid(fetch_valid), .fetch_tag(fetch_tag), .fetch_data(fetch_data), .fetch_ready(fetch_ready),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .adder_done(adder_done), .mult_done(mult_done), .fetch_done(fetch_done),
    .bad_tag(bad_tag)
  );

  int total = 0;
  int bad = 0;

  // Reference model: one FIFO queue of {tag,data} per unit plus a round-robin start unit.
  bit [11:0] mq [3][$];
  int        rr_m;
  bit        exp_valid;
  bit [3:0]  exp_tag;
  bit [7:0]  exp_data;
  bit [5:0]  exp_done;
  bit        exp_bad;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic model_step();
    bit       iv [3];
    bit [3:0] it [3];
    bit [7:0] id [3];
    bit       acc [3];
    int       g;
    int       u2;
    bit [11:0] b;
    iv[0] = add_valid;   it[0] = add_tag;   id[0] = add_data;
    iv[1] = mult_valid;  it[1] = mult_tag;  id[1] = mult_data;
    iv[2] = fetch_valid; it[2] = fetch_tag; id[2] = fetch_data;
    if (rst) begin
      for (int u = 0; u < 3; u++) mq[u].delete();
      rr_m = 0; exp_valid = 0; exp_tag = 0; exp_data = 0; exp_done = 0; exp_bad = 0;
      return;
    end
    for (int u = 0; u < 3; u++) acc[u] = iv[u] && (mq[u].size() < DEPTH);
    g = -1;
    for (int k = 0; k < 3; k++) begin
      u2 = (rr_m + k) % 3;
      if (g < 0 && mq[u2].size() > 0) g = u2;
    end
    if (g >= 0) begin
      b = mq[g].pop_front();
      exp_valid = 1; exp_tag = b[11:8]; exp_data = b[7:0];
      exp_done = 6'b1 << (int'(b[11:8]) - 1);
      rr_m = (g + 1) % 3;
    end else begin
      exp_valid = 0; exp_tag = 0; exp_data = 0; exp_done = 0;
    end
    exp_bad = 0;
    for (int u = 0; u < 3; u++) begin
      if (acc[u]) begin
        if (it[u] == 4'(2 * u + 1) || it[u] == 4'(2 * u + 2)) mq[u].push_back({it[u], id[u]});
        else exp_bad = 1;
      end
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check("cdb_valid", 32'(cdb_valid), 32'(exp_valid));
    check("cdb_tag", 32'(cdb_tag), 32'(exp_tag));
    check("cdb_data", 32'(cdb_data), 32'(exp_data));
    check("done", 32'({fetch_done, mult_done, adder_done}), 32'(exp_done));
    check("bad_tag", 32'(bad_tag), 32'(exp_bad));
    check("add_ready", 32'(add_ready), 32'(mq[0].size() < DEPTH));
    check("mult_ready", 32'(mult_ready), 32'(mq[1].size() < DEPTH));
    check("fetch_ready", 32'(fetch_ready), 32'(mq[2].size() < DEPTH));
  endtask

  task automatic idle();
    add_valid = 0;   add_tag = 0;   add_data = 0;
    mult_valid = 0;  mult_tag = 0;  mult_data = 0;
    fetch_valid = 0; fetch_tag = 0; fetch_data = 0;
  endtask

  initial begin
    int mi;
    int got_n;
    int got [4];
    bit saw_full;
    bit adv;
    rr_m = 0;
    rst = 1;
    idle();

    // Reset
    cycle();
    cycle();
    check("rst_cdb", 32'({cdb_valid, cdb_tag, cdb_data}), 32'(0));
    check("rst_ready", 32'({add_ready, mult_ready, fetch_ready}), 32'(3'b111));
    check("rst_bad", 32'(bad_tag), 32'(0));
    rst = 0;

    // Single beat latency
    add_valid = 1; add_tag = 4'd1; add_data = 8'h2A;
    cycle();
    idle();
    cycle();
    check("single_valid", 32'(cdb_valid), 32'(1));
    check("single_tag", 32'(cdb_tag), 32'(1));
    check("single_data", 32'(cdb_data), 32'(8'h2A));
    check("single_done", 32'(adder_done), 32'(2'b01));
    cycle();
    check("single_idle", 32'({cdb_valid, cdb_tag, cdb_data, adder_done}), 32'(0));

    rst = 1;
    cycle();
    rst = 0;

    // Contention from all three units in one edge
    add_valid = 1;   add_tag = 4'd2;   add_data = 8'h11;
    mult_valid = 1;  mult_tag = 4'd3;  mult_data = 8'h22;
    fetch_valid = 1; fetch_tag = 4'd6; fetch_data = 8'h33;
    cycle();
    idle();
    cycle();
    check("cont_tag0", 32'(cdb_tag), 32'(2));
    cycle();
    check("cont_tag1", 32'(cdb_tag), 32'(3));
    cycle();
    check("cont_tag2", 32'(cdb_tag), 32'(6));
    check("cont_fdone", 32'(fetch_done), 32'(2'b10));

    // Fairness under continuous offers
    for (int j = 0; j < 12; j++) begin
      add_valid = 1;   add_tag = 4'(1 + j % 2);   add_data = 8'(j);
      mult_valid = 1;  mult_tag = 4'(3 + j % 2);  mult_data = 8'(j + 8'h40);
      fetch_valid = 1; fetch_tag = 4'(5 + j % 2); fetch_data = 8'(j + 8'h80);
      cycle();
      if (j >= 1) begin
        check("rr_valid", 32'(cdb_valid), 32'(1));
        check("rr_unit", 32'((int'(cdb_tag) - 1) / 2), 32'((j - 1) % 3));
      end
    end
    idle();
    for (int j = 0; j < 8; j++) cycle();

    // Mult buffer fill and pointer wrap
    mi = 0; got_n = 0; saw_full = 0;
    for (int c = 0; c < 60 && got_n < 4; c++) begin
      add_valid = (mi < 4);   add_tag = 4'd1;   add_data = 8'(c);
      fetch_valid = (mi < 4); fetch_tag = 4'd5; fetch_data = 8'(c + 100);
      mult_valid = (mi < 4);  mult_tag = 4'd3;  mult_data = 8'(mi + 1);
      if (mult_valid && !mult_ready) saw_full = 1;
      adv = mult_valid && mult_ready;
      cycle();
      if (adv) mi++;
      if (cdb_valid && cdb_tag == 4'd3 && got_n < 4) begin
        got[got_n] = int'(cdb_data);
        got_n++;
      end
    end
    check("mult_full_seen", 32'(saw_full), 32'(1));
    check("mult_delivered", 32'(got_n), 32'(4));
    for (int k = 0; k < 4; k++) check("mult_order", 32'(got[k]), 32'(k + 1));
    idle();
    for (int j = 0; j < 8; j++) cycle();

    // Illegal tag, then reset with results still buffered
    check("bad_pre_ready", 32'(add_ready), 32'(1));
    add_valid = 1; add_tag = 4'd5; add_data = 8'h77;
    cycle();
    idle();
    check("bad_pulse", 32'(bad_tag), 32'(1));
    check("bad_nocdb", 32'(cdb_valid), 32'(0));
    cycle();
    check("bad_clear", 32'(bad_tag), 32'(0));
    check("bad_nocdb2", 32'(cdb_valid), 32'(0));
    add_valid = 1;  add_tag = 4'd1;  add_data = 8'hAA;
    mult_valid = 1; mult_tag = 4'd4; mult_data = 8'hBB;
    cycle();
    idle();
    rst = 1;
    cycle();
    check("rstmid_cdb", 32'(cdb_valid), 32'(0));
    rst = 0;
    for (int j = 0; j < 4; j++) begin
      cycle();
      check("rstmid_idle", 32'(cdb_valid), 32'(0));
      check("rstmid_ready", 32'({add_ready, mult_ready, fetch_ready}), 32'(3'b111));
    end

    // Random traffic with legal and illegal tags and occasional reset
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 59) == 0);
      add_valid = ($urandom_range(0, 99) < 60);
      add_tag = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'(1 + $urandom_range(0, 1));
      add_data = 8'($urandom);
      mult_valid = ($urandom_range(0, 99) < 60);
      mult_tag = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'(3 + $urandom_range(0, 1));
      mult_data = 8'($urandom);
      fetch_valid = ($urandom_range(0, 99) < 60);
      fetch_tag = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'(5 + $urandom_range(0, 1));
      fetch_data = 8'($urandom);
      cycle();
    end
    rst = 0;
    idle();
    for (int j = 0; j < 8; j++) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
